// File: rtl/uart_recv_pkg.sv
// Shared definitions for the UART receiver: default bit period, data width and FSM state encodings.
package uart_recv_pkg;

  localparam logic [15:0] BPS_CNT_DEF = 16'd434;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned BIT_W       = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous receive line into the clock domain and flags its falling edges.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_s,
  output logic fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_dly;

  // Reset to 1 so that leaving reset with an idle-high line never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_dly   <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign rxd_s = r_sync2;
  assign fall  = r_dly & ~r_sync2;

endmodule

// File: rtl/uart_recv.sv
// UART 8N1 receiver, LSB first: qualifies the start bit at its centre, samples data and stop at bit centres.
module uart_recv
  import uart_recv_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = BPS_CNT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rxd,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_done,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam logic [15:0]      HALF_M1 = (BPS_CNT / 16'd2) - 16'd1;
  localparam logic [15:0]      BIT_M1  = BPS_CNT - 16'd1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic w_rxd_s;
  logic w_fall;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rxd_s     (w_rxd_s),
    .fall      (w_fall)
  );

  rx_state_e         r_state,     w_state_nxt;
  logic [15:0]       r_clk_cnt,   w_clk_cnt_nxt;
  logic [BIT_W-1:0]  r_bit_cnt,   w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shift,     w_shift_nxt;
  logic [DATA_W-1:0] r_rx_byte,   w_rx_byte_nxt;
  logic              r_rx_done,   w_rx_done_nxt;
  logic              r_frame_err, w_frame_err_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_byte   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_byte   <= w_rx_byte_nxt;
      r_rx_done   <= w_rx_done_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rx_byte_nxt   = r_rx_byte;
    w_rx_done_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (w_fall) w_state_nxt = ST_START;
      end

      // A line that is high again at the start-bit centre was a glitch.
      ST_START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end

      ST_DATA: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_cnt] = w_rxd_s;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end

      // Leaving at mid-stop lets a back-to-back start edge be caught on time.
      ST_STOP: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
          if (w_rxd_s) begin
            w_rx_byte_nxt = r_shift;
            w_rx_done_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rx_byte   = r_rx_byte;
  assign rx_done   = r_rx_done;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule
